alu_toplevel: RTL and testbench

//   16-bit combinational-datapath ALU with a registered result, used as the

---
 rtl/alu_toplevel.sv | 63 ++++++
 tb/tb_alu_toplevel.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/alu_toplevel.sv
// alu_toplevel: 16-bit ALU with eight operations selected by FS.
// The result and its zero flag are captured together on the rising clock edge.
// An asynchronous active-high reset clears the result and sets the zero flag.
module alu_toplevel (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  FS,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic [15:0] out,
   output logic        zero_flag
);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } alu_op_e;

   logic [15:0] w_result;
   logic        w_zero;
   logic [15:0] r_out;
   logic        r_zero;

   // Combinational operation select; carries and borrows are simply dropped
   always_comb begin
      w_result = 16'h0000;
      case (alu_op_e'(FS))
         OP_ADD:  w_result = A + B;
         OP_SUB:  w_result = A - B;
         OP_AND:  w_result = A & B;
         OP_OR:   w_result = A | B;
         OP_XOR:  w_result = A ^ B;
         OP_NOT:  w_result = ~A;
         OP_SHL:  w_result = {A[14:0], 1'b0};
         OP_SHR:  w_result = {1'b0, A[15:1]};
         default: w_result = 16'h0000;
      endcase
   end

   // The flag comes from the result being loaded, so it always agrees with out
   assign w_zero = (w_result == 16'h0000);

   // Result register; reset leaves a coherent zero result with its flag set
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out  <= 16'h0000;
         r_zero <= 1'b1;
      end else begin
         r_out  <= w_result;
         r_zero <= w_zero;
      end
   end

   assign out       = r_out;
   assign zero_flag = r_zero;

endmodule

// File: tb/tb_alu_toplevel.sv
// tb_alu_toplevel: scoreboard bench for alu_toplevel.
// Each issued operation pushes its expected result; the result is popped and
// compared one clock edge later, just after the edge that loads it.
module tb_alu_toplevel;

   logic        clk;
   logic        rst;
   logic [2:0]  FS;
   logic [15:0] A;
   logic [15:0] B;
   logic [15:0] out;
   logic        zero_flag;

   typedef struct packed {
      logic [15:0] res;
      logic        zero;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp;
   int   n_err;

   alu_toplevel dut (
      .clk       (clk),
      .rst       (rst),
      .FS        (FS),
      .A         (A),
      .B         (B),
      .out       (out),
      .zero_flag (zero_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, want);
      end
   endtask

   // Reference model written from the operation table
   function automatic logic [15:0] ref_alu(input logic [2:0] f, input logic [15:0] a,
                                           input logic [15:0] b);
      logic [16:0] wide;
      case (f)
         3'd0: begin wide = {1'b0, a} + {1'b0, b}; return wide[15:0]; end
         3'd1: begin wide = {1'b0, a} + {1'b0, ~b} + 17'd1; return wide[15:0]; end
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return a ^ 16'hFFFF;
         3'd6: return a * 16'd2;
         default: return a / 16'd2;
      endcase
   endfunction

   // Drive one operation, push its expectation, compare just after the edge
   task automatic op(input string tag, input logic [2:0] f, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] want, input logic wz);
      exp_t e;
      exp_t p;
      FS = f;
      A  = a;
      B  = b;
      e.res  = want;
      e.zero = wz;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
         p = exp_q.pop_front();
         chk({tag, "_out"}, {16'h0, out}, {16'h0, p.res});
         chk({tag, "_zero"}, {31'h0, zero_flag}, {31'h0, p.zero});
      end
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic [2:0]  rf;
      logic [15:0] rw;
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      FS  = 3'd0;
      A   = 16'h0;
      B   = 16'h0;

      // Reset held across edges
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out", {16'h0, out}, 32'h0);
      chk("reset_zero", {31'h0, zero_flag}, 32'h1);
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors from the operation table
      op("add_29cb", 3'd0, 16'h29CB, 16'h29CB, 16'h5396, 1'b0);
      op("sub_29cb", 3'd1, 16'h29CB, 16'h29CB, 16'h0000, 1'b1);
      op("and_29cb", 3'd2, 16'h29CB, 16'h29CB, 16'h29CB, 1'b0);
      op("or_29cb",  3'd3, 16'h29CB, 16'h29CB, 16'h29CB, 1'b0);
      op("xor_29cb", 3'd4, 16'h29CB, 16'h29CB, 16'h0000, 1'b1);
      op("not_29cb", 3'd5, 16'h29CB, 16'h1234, 16'hD634, 1'b0);
      op("shl_29cb", 3'd6, 16'h29CB, 16'hFFFF, 16'h5396, 1'b0);
      op("shr_29cb", 3'd7, 16'h29CB, 16'h0000, 16'h14E5, 1'b0);
      op("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
      op("sub_wrap", 3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0);
      op("shl_msb",  3'd6, 16'h8001, 16'h0000, 16'h0002, 1'b0);
      op("shr_msb",  3'd7, 16'h8001, 16'h0000, 16'h4000, 1'b0);
      op("shl_zero", 3'd6, 16'h8000, 16'h0000, 16'h0000, 1'b1);

      // Result must hold steady until the next edge
      #3;
      chk("hold_out", {16'h0, out}, 32'h0);
      chk("hold_zero", {31'h0, zero_flag}, 32'h1);

      // Load a non-zero result, then assert reset between edges
      op("pre_rst", 3'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_out", {16'h0, out}, 32'h0);
      chk("async_rst_zero", {31'h0, zero_flag}, 32'h1);
      FS = 3'd5;
      A  = 16'h0000;
      @(posedge clk);
      #1;
      chk("rst_hold_out", {16'h0, out}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      op("post_rst", 3'd5, 16'h0000, 16'h0000, 16'hFFFF, 1'b0);

      // Back-to-back random operations, FS changing every cycle
      for (int i = 0; i < 40; i++) begin
         rf = 3'(i % 8);
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 10 == 3) rb = ra;
         rw = ref_alu(rf, ra, rb);
         op("rand", rf, ra, rb, rw, (rw == 16'h0000));
      end

      chk("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
